// File: rtl/register_write_arbiter.sv
// Two-requester round-robin arbiter in front of a register file write/move port.
// Accepts one WRITE or MOVE per cycle and presents it on the rf* outputs for exactly one cycle.
module register_write_arbiter #(
   parameter int unsigned DATA_WIDTH       = 32,
   parameter int unsigned RFILE_ADDR_WIDTH = 5
) (
   input  logic                        clock,
   input  logic                        resetN,
   input  logic                        aValid,
   output logic                        aReady,
   input  logic                        aOp,
   input  logic [RFILE_ADDR_WIDTH-1:0] aAddr,
   input  logic [RFILE_ADDR_WIDTH-1:0] aSrcAddr,
   input  logic [DATA_WIDTH-1:0]       aData,
   input  logic                        bValid,
   output logic                        bReady,
   input  logic                        bOp,
   input  logic [RFILE_ADDR_WIDTH-1:0] bAddr,
   input  logic [RFILE_ADDR_WIDTH-1:0] bSrcAddr,
   input  logic [DATA_WIDTH-1:0]       bData,
   input  logic [RFILE_ADDR_WIDTH-1:0] cpuReadAddr1,
   input  logic [RFILE_ADDR_WIDTH-1:0] cpuReadAddr2,
   output logic                        readStall,
   output logic [1:0]                  rfWriteMoveEnable,
   output logic [RFILE_ADDR_WIDTH-1:0] rfWriteAddr,
   output logic [DATA_WIDTH-1:0]       rfWriteData,
   output logic [RFILE_ADDR_WIDTH-1:0] rfReadMoveAddr1,
   output logic [RFILE_ADDR_WIDTH-1:0] rfReadMoveAddr2
);

   localparam logic OP_WRITE = 1'b0;
   localparam logic OP_MOVE  = 1'b1;

   // Encoding doubles as the rfWriteMoveEnable value presented in each state.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_WRITE = 2'b01,
      ST_MOVE  = 2'b10
   } state_t;

   state_t                        r_state;
   state_t                        w_state_nxt;
   logic                          r_last_grant_b;
   logic                          w_grant_a;
   logic                          w_grant_b;
   logic                          w_xfer;
   logic                          w_op;
   logic [RFILE_ADDR_WIDTH-1:0]   w_addr;
   logic [RFILE_ADDR_WIDTH-1:0]   w_src;
   logic [DATA_WIDTH-1:0]         w_data;
   logic [RFILE_ADDR_WIDTH-1:0]   r_wr_addr;
   logic [DATA_WIDTH-1:0]         r_wr_data;
   logic [RFILE_ADDR_WIDTH-1:0]   r_mv_dst;
   logic [RFILE_ADDR_WIDTH-1:0]   r_mv_src;

   // Round-robin grant; gated by reset so ready drops the moment reset asserts.
   always_comb begin
      w_grant_a = resetN && aValid && (!bValid || r_last_grant_b);
      w_grant_b = resetN && bValid && !w_grant_a;
      w_xfer    = w_grant_a || w_grant_b;
      w_op      = w_grant_a ? aOp      : bOp;
      w_addr    = w_grant_a ? aAddr    : bAddr;
      w_src     = w_grant_a ? aSrcAddr : bSrcAddr;
      w_data    = w_grant_a ? aData    : bData;
   end

   assign aReady = w_grant_a;
   assign bReady = w_grant_b;

   // Issue FSM state register.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state depends only on what was accepted this cycle.
   always_comb begin
      w_state_nxt = ST_IDLE;
      if (w_xfer) begin
         w_state_nxt = (w_op == OP_MOVE) ? ST_MOVE : ST_WRITE;
      end
   end

   // Arbitration history and command capture on transfer.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         r_last_grant_b <= 1'b1;
         r_wr_addr      <= '0;
         r_wr_data      <= '0;
         r_mv_dst       <= '0;
         r_mv_src       <= '0;
      end else begin
         if (w_xfer) begin
            r_last_grant_b <= w_grant_b;
         end
         if (w_xfer && (w_op == OP_WRITE)) begin
            r_wr_addr <= w_addr;
            r_wr_data <= w_data;
         end
         if (w_xfer && (w_op == OP_MOVE)) begin
            r_mv_dst <= w_addr;
            r_mv_src <= w_src;
         end
      end
   end

   // Read ports are borrowed only while a MOVE is on the port.
   always_comb begin
      rfWriteMoveEnable = 2'(r_state);
      readStall         = (r_state == ST_MOVE);
      rfWriteAddr       = r_wr_addr;
      rfWriteData       = r_wr_data;
      rfReadMoveAddr1   = cpuReadAddr1;
      rfReadMoveAddr2   = cpuReadAddr2;
      if (r_state == ST_MOVE) begin
         rfReadMoveAddr1 = r_mv_dst;
         rfReadMoveAddr2 = r_mv_src;
      end
   end

endmodule
